// File: rtl/rv32i_imem_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states, streak width
// and the buffered loader write request.
package rv32i_imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } imem_arb_state_t;

  localparam int unsigned IMEM_STREAK_W = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } imem_req_t;

  function automatic logic imem_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_imem_wr_buffer.sv
// Single-entry loader write buffer; misaligned writes are dropped with a
// one-cycle error pulse and leave the buffer empty.
module rv32i_imem_wr_buffer
  import rv32i_imem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_release,
  output logic        o_full,
  output logic        o_err,
  output imem_req_t   o_req
);

  logic      full_q, full_d;
  logic      err_q, err_d;
  imem_req_t req_q, req_d;

  always_comb begin
    full_d = full_q;
    err_d  = 1'b0;
    req_d  = req_q;
    if (i_release) begin
      full_d = 1'b0;
    end
    if (i_accept) begin
      if (imem_misaligned(i_addr)) begin
        err_d = 1'b1;
      end else begin
        full_d = 1'b1;
        req_d  = '{addr: i_addr, data: i_data};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q <= 1'b0;
      err_q  <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      err_q  <= err_d;
      req_q  <= req_d;
    end
  end

  assign o_full = full_q;
  assign o_err  = err_q;
  assign o_req  = req_q;

endmodule

// File: rtl/rv32i_imem_arbiter.sv
// Shares the multicycle instruction memory between fetch reads and loader
// writes: write priority with a bounded burst, and flush-driven read abort.
module rv32i_imem_arbiter
  import rv32i_imem_pkg::*;
#(
  parameter int unsigned WR_BURST_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_rd_en,
  input  logic [31:0] i_fetch_rd_addr,
  input  logic        i_fetch_flush,
  output logic [31:0] o_fetch_rd_data,
  output logic        o_fetch_rd_valid,
  input  logic        i_load_wr_en,
  input  logic [31:0] i_load_wr_addr,
  input  logic [31:0] i_load_wr_data,
  output logic        o_load_wr_ready,
  output logic        o_load_wr_done,
  output logic        o_load_wr_err,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_rd_addr,
  input  logic [31:0] i_mem_rd_data,
  input  logic        i_mem_rd_valid,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_wr_addr,
  output logic [31:0] o_mem_wr_data,
  input  logic        i_mem_wr_valid,
  output logic        o_mem_rst
);

  localparam logic [IMEM_STREAK_W-1:0] STREAK_MAX = IMEM_STREAK_W'(WR_BURST_MAX);

  imem_arb_state_t          state_q, state_d;
  logic [IMEM_STREAK_W-1:0] streak_q, streak_d;
  logic [31:0]              rd_addr_q, rd_addr_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     wr_done_q, wr_done_d;
  logic                     mem_rd_en_q, mem_rd_en_d;
  logic                     mem_wr_en_q, mem_wr_en_d;

  logic      buf_full;
  logic      buf_err;
  logic      buf_accept;
  logic      buf_release;
  imem_req_t buf_req;

  assign buf_accept  = i_load_wr_en & ~buf_full;
  assign buf_release = (state_q == WRITE) & i_mem_wr_valid;

  rv32i_imem_wr_buffer u_wr_buffer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_accept  (buf_accept),
    .i_addr    (i_load_wr_addr),
    .i_data    (i_load_wr_data),
    .i_release (buf_release),
    .o_full    (buf_full),
    .o_err     (buf_err),
    .o_req     (buf_req)
  );

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!i_fetch_flush) begin
          if (buf_full && (streak_q < STREAK_MAX || !i_fetch_rd_en)) begin
            state_d = WRITE;
          end else if (i_fetch_rd_en) begin
            state_d   = READ;
            rd_addr_d = i_fetch_rd_addr;
            streak_d  = '0;
          end
        end
      end
      READ: begin
        // Flush wins over a same-cycle memory response: the data is discarded.
        if (i_fetch_flush) begin
          state_d = FLUSH;
        end else if (i_mem_rd_valid) begin
          rd_data_d  = i_mem_rd_data;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WRITE: begin
        if (i_mem_wr_valid) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
          if (i_fetch_rd_en) begin
            streak_d = (streak_q == '1) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mem_rd_en_d = (state_d == READ);
    mem_wr_en_d = (state_d == WRITE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_done_q   <= wr_done_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
    end
  end

  assign o_fetch_rd_data  = rd_data_q;
  assign o_fetch_rd_valid = rd_valid_q;
  assign o_load_wr_ready  = ~buf_full;
  assign o_load_wr_done   = wr_done_q;
  assign o_load_wr_err    = buf_err;
  assign o_mem_rd_en      = mem_rd_en_q;
  assign o_mem_rd_addr    = rd_addr_q;
  assign o_mem_wr_en      = mem_wr_en_q;
  assign o_mem_wr_addr    = buf_req.addr;
  assign o_mem_wr_data    = buf_req.data;
  assign o_mem_rst        = i_rst | (state_q == FLUSH);

endmodule

// File: tb/tb_rv32i_imem_arbiter.sv
// Scoreboard bench for rv32i_imem_arbiter with a latency-programmable memory model.
module tb_rv32i_imem_arbiter;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_fetch_rd_en = 1'b0;
  logic [31:0] i_fetch_rd_addr = '0;
  logic        i_fetch_flush = 1'b0;
  logic [31:0] o_fetch_rd_data;
  logic        o_fetch_rd_valid;
  logic        i_load_wr_en = 1'b0;
  logic [31:0] i_load_wr_addr = '0;
  logic [31:0] i_load_wr_data = '0;
  logic        o_load_wr_ready;
  logic        o_load_wr_done;
  logic        o_load_wr_err;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_rd_addr;
  logic [31:0] i_mem_rd_data = '0;
  logic        i_mem_rd_valid = 1'b0;
  logic        o_mem_wr_en;
  logic [31:0] o_mem_wr_addr;
  logic [31:0] o_mem_wr_data;
  logic        i_mem_wr_valid = 1'b0;
  logic        o_mem_rst;

  rv32i_imem_arbiter #(.WR_BURST_MAX(4)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_fetch_rd_en    (i_fetch_rd_en),
    .i_fetch_rd_addr  (i_fetch_rd_addr),
    .i_fetch_flush    (i_fetch_flush),
    .o_fetch_rd_data  (o_fetch_rd_data),
    .o_fetch_rd_valid (o_fetch_rd_valid),
    .i_load_wr_en     (i_load_wr_en),
    .i_load_wr_addr   (i_load_wr_addr),
    .i_load_wr_data   (i_load_wr_data),
    .o_load_wr_ready  (o_load_wr_ready),
    .o_load_wr_done   (o_load_wr_done),
    .o_load_wr_err    (o_load_wr_err),
    .o_mem_rd_en      (o_mem_rd_en),
    .o_mem_rd_addr    (o_mem_rd_addr),
    .i_mem_rd_data    (i_mem_rd_data),
    .i_mem_rd_valid   (i_mem_rd_valid),
    .o_mem_wr_en      (o_mem_wr_en),
    .o_mem_wr_addr    (o_mem_wr_addr),
    .o_mem_wr_data    (o_mem_wr_data),
    .i_mem_wr_valid   (i_mem_wr_valid),
    .o_mem_rst        (o_mem_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam logic [7:0] ORD_R = 8'h52;
  localparam logic [7:0] ORD_W = 8'h57;

  rd_exp_t     exp_rd_q[$];
  wr_t         exp_wr_q[$];
  wr_t         commit_q[$];
  logic [7:0]  exp_order_q[$];
  logic [31:0] exp_err_q[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned valid_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned rd_lat = 0;
  int unsigned wr_lat = 0;
  bit          burst_mode = 1'b0;
  bit          race_flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory model; also owns i_fetch_flush so races with responses are exact.
  logic [31:0] mem [logic [31:0]];
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  always @(negedge clk) begin
    wr_t c;
    i_mem_rd_valid = 1'b0;
    i_mem_wr_valid = 1'b0;
    i_fetch_flush  = 1'b0;
    if (o_mem_rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (o_mem_rd_en) begin
        if (rd_cnt == rd_lat) begin
          i_mem_rd_valid = 1'b1;
          i_mem_rd_data  = mem.exists(o_mem_rd_addr) ? mem[o_mem_rd_addr] : mem_default(o_mem_rd_addr);
          rd_cnt = 0;
          if (race_flush) i_fetch_flush = 1'b1;
        end else begin
          rd_cnt++;
        end
      end else begin
        rd_cnt = 0;
      end
      if (o_mem_wr_en) begin
        if (wr_cnt == wr_lat) begin
          i_mem_wr_valid = 1'b1;
          mem[o_mem_wr_addr] = o_mem_wr_data;
          c.addr = o_mem_wr_addr;
          c.data = o_mem_wr_data;
          commit_q.push_back(c);
          wr_cnt = 0;
        end else begin
          wr_cnt++;
        end
      end else begin
        wr_cnt = 0;
      end
    end
    if (burst_mode && o_load_wr_done) i_fetch_flush = 1'b1;
  end

  // Monitor / scoreboard.
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    rd_exp_t e;
    wr_t     w;
    wr_t     c;
    check("mem_en_exclusive", {31'b0, o_mem_rd_en & o_mem_wr_en}, 32'd0);
    if (o_mem_rd_en && !prev_rd) begin
      if (exp_order_q.size() == 0) fail_event("grant_order", "read grant");
      else check("grant_order", {24'b0, ORD_R}, {24'b0, exp_order_q.pop_front()});
    end
    if (o_mem_wr_en && !prev_wr) begin
      if (exp_order_q.size() == 0) fail_event("grant_order", "write grant");
      else check("grant_order", {24'b0, ORD_W}, {24'b0, exp_order_q.pop_front()});
    end
    if (o_fetch_rd_valid) begin
      valid_cnt++;
      if (exp_rd_q.size() == 0) fail_event("fetch_valid", "read valid");
      else begin
        e = exp_rd_q.pop_front();
        check("fetch_data", o_fetch_rd_data, e.data);
        if (e.cyc != 0) check("fetch_latency", cyc, e.cyc);
      end
    end
    if (o_load_wr_done) begin
      done_cnt++;
      if (exp_wr_q.size() == 0 || commit_q.size() == 0) fail_event("wr_done", "write done");
      else begin
        w = exp_wr_q.pop_front();
        c = commit_q.pop_front();
        check("wr_addr", c.addr, w.addr);
        check("wr_data", c.data, w.data);
      end
    end
    if (o_load_wr_err) begin
      err_cnt++;
      if (exp_err_q.size() == 0) fail_event("wr_err", "error pulse");
      else void'(exp_err_q.pop_front());
    end
    prev_rd = o_mem_rd_en;
    prev_wr = o_mem_wr_en;
  end

  task automatic wait_fetch_valid(input string name);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_fetch_rd_valid && n < 50);
    if (!o_fetch_rd_valid) fail_event(name, "timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sent;
    bit          fetch_done;
    wr_t         w;
    logic        exp_flush_rd [1:6];
    int unsigned n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_rst", o_mem_rst, 1);
    check("rst_ready", o_load_wr_ready, 1);
    check("rst_rd_en", o_mem_rd_en, 0);
    check("rst_wr_en", o_mem_wr_en, 0);
    check("rst_valid", o_fetch_rd_valid, 0);
    check("rst_done", o_load_wr_done, 0);
    check("rst_rd_data", o_fetch_rd_data, 0);
    i_rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_rst", o_mem_rst, 0);

    // Single read, k=2: valid 4 cycles after the request is sampled
    rd_lat = 2;
    exp_order_q.push_back(ORD_R);
    exp_rd_q.push_back('{data: 32'h0000_0013, cyc: cyc + 4});
    i_fetch_rd_en   = 1'b1;
    i_fetch_rd_addr = 32'h10;
    wait_fetch_valid("rd_timeout");
    i_fetch_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_single_pulse", valid_cnt, 1);

    // Write burst with a pending fetch: 4 writes, 1 read, 2 writes
    rd_lat = 1;
    wr_lat = 1;
    burst_mode = 1'b1;
    exp_order_q.push_back(ORD_W);
    exp_order_q.push_back(ORD_W);
    exp_order_q.push_back(ORD_W);
    exp_order_q.push_back(ORD_W);
    exp_order_q.push_back(ORD_R);
    exp_order_q.push_back(ORD_W);
    exp_order_q.push_back(ORD_W);
    for (int i = 0; i < 6; i++) begin
      w.addr = 32'(i * 4);
      w.data = 32'hD000_0000 | 32'(i * 4);
      exp_wr_q.push_back(w);
    end
    exp_rd_q.push_back('{data: 32'hD000_0008, cyc: 0});
    sent = 0;
    fetch_done = 1'b0;
    n = 0;
    while (!(done_cnt >= 6 && fetch_done) && n < 300) begin
      if (o_fetch_rd_valid) begin
        fetch_done = 1'b1;
        i_fetch_rd_en = 1'b0;
      end else if (sent >= 1 && !fetch_done) begin
        i_fetch_rd_en   = 1'b1;
        i_fetch_rd_addr = 32'h8;
      end
      if (o_load_wr_ready && sent < 6) begin
        i_load_wr_en   = 1'b1;
        i_load_wr_addr = 32'(sent * 4);
        i_load_wr_data = 32'hD000_0000 | 32'(sent * 4);
        sent++;
      end else begin
        i_load_wr_en = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    i_load_wr_en = 1'b0;
    i_fetch_rd_en = 1'b0;
    burst_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("burst_done_count", done_cnt, 6);
    check("burst_valid_count", valid_cnt, 2);

    // Flush in the same cycle as the memory response, then re-fetch 0x20
    exp_flush_rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rd_lat = 1;
    race_flush = 1'b1;
    exp_order_q.push_back(ORD_R);
    i_fetch_rd_en   = 1'b1;
    i_fetch_rd_addr = 32'h40;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("flush_mem_rst", o_mem_rst, (i == 3));
      check("flush_rd_en", o_mem_rd_en, exp_flush_rd[i]);
      if (i == 3) begin
        race_flush = 1'b0;
        exp_order_q.push_back(ORD_R);
        exp_rd_q.push_back('{data: 32'hA5A5_0020, cyc: cyc + 4});
        i_fetch_rd_addr = 32'h20;
      end
    end
    wait_fetch_valid("flush_rd_timeout");
    i_fetch_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_valid_count", valid_cnt, 3);

    // Misaligned loader write is dropped
    exp_err_q.push_back(32'h6);
    i_load_wr_en   = 1'b1;
    i_load_wr_addr = 32'h6;
    i_load_wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    i_load_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("misalign_ready", o_load_wr_ready, 1);
      check("misalign_wr_en", o_mem_wr_en, 0);
      @(negedge clk);
    end
    check("misalign_err_count", err_cnt, 1);

    // Reset while a write is in progress
    wr_lat = 20;
    exp_order_q.push_back(ORD_W);
    i_load_wr_en   = 1'b1;
    i_load_wr_addr = 32'h30;
    i_load_wr_data = 32'h1234_5678;
    @(negedge clk);
    i_load_wr_en = 1'b0;
    n = 0;
    while (!o_mem_wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!o_mem_wr_en) fail_event("rstw_timeout", "timeout");
    i_rst = 1'b1;
    @(negedge clk);
    check("rstw_mem_rst_1", o_mem_rst, 1);
    check("rstw_ready_in_rst", o_load_wr_ready, 1);
    @(negedge clk);
    check("rstw_mem_rst_2", o_mem_rst, 1);
    i_rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", o_load_wr_ready, 1);
    check("rstw_rd_en", o_mem_rd_en, 0);
    check("rstw_wr_en", o_mem_wr_en, 0);
    check("rstw_mem_rst_off", o_mem_rst, 0);
    repeat (4) @(negedge clk);
    check("rstw_no_done", done_cnt, 6);
    wr_lat = 1;

    check("end_rd_queue", exp_rd_q.size(), 0);
    check("end_wr_queue", exp_wr_q.size(), 0);
    check("end_order_queue", exp_order_q.size(), 0);
    check("end_err_queue", exp_err_q.size(), 0);
    check("end_valid_count", valid_cnt, 3);
    check("end_err_count", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
